// File: rtl/ball_render.sv
// ball_render: latches the ball position once per frame, rasterises a square
// ball against the video beam and reports wall/paddle overlap as horizontal
// and vertical hits at the end of each frame.
module ball_render #(
  parameter int BALL_SIZE = 4,
  parameter int H_DISPLAY = 256,
  parameter int V_DISPLAY = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic [8:0] ball_hpos,
  input  logic [8:0] ball_vpos,
  input  logic       playfield_gfx,
  output logic       ball_gfx,
  output logic       hit_horiz,
  output logic       hit_vert,
  output logic       frame_done
);

  localparam logic [3:0] SZ      = 4'(BALL_SIZE);
  localparam logic [3:0] SZ_LAST = 4'(BALL_SIZE - 1);
  localparam logic [9:0] H_END   = 10'(H_DISPLAY);
  localparam logic [8:0] V_END   = 9'(V_DISPLAY);
  localparam logic [8:0] OFFSCR  = 9'h1FF;

  logic [8:0] r_bh;
  logic [8:0] r_bv;
  logic [3:0] r_vcnt;
  logic [3:0] r_hcnt;
  logic       r_stickyH;
  logic       r_stickyV;
  logic       r_ballGfx;
  logic       r_hitHoriz;
  logic       r_hitVert;
  logic       r_frameDone;

  logic       w_frameStart;
  logic       w_frameEnd;
  logic       w_lineStart;
  logic [8:0] w_bh;
  logic [8:0] w_bv;
  logic [3:0] w_vcnt;
  logic [3:0] w_hcnt;
  logic       w_rowActive;
  logic       w_inLine;
  logic       w_pixel;
  logic [3:0] w_rowIdx;
  logic [3:0] w_colIdx;
  logic       w_edgeRow;
  logic       w_edgeCol;
  logic       w_hitH;
  logic       w_hitV;

  assign w_frameStart = (hpos == 9'd0) && (vpos == 9'd0);
  assign w_frameEnd   = (hpos == 9'd0) && (vpos == V_END);
  assign w_lineStart  = (hpos == 9'd0);

  // The frame-start cycle already uses the freshly latched position, so a
  // ball at (0,0) is drawn in the very cycle it is latched.
  assign w_bh = w_frameStart ? ball_hpos : r_bh;
  assign w_bv = w_frameStart ? ball_vpos : r_bv;

  // Row counter: loaded on the ball's top line, counts lines down to zero;
  // a new frame discards any rows left over from a ball near the bottom.
  always_comb begin
    w_vcnt = r_vcnt;
    if (w_lineStart) begin
      if ((vpos == w_bv) && (w_bv != OFFSCR)) begin
        w_vcnt = SZ;
      end else if (w_frameStart) begin
        w_vcnt = 4'd0;
      end else if (r_vcnt != 4'd0) begin
        w_vcnt = r_vcnt - 4'd1;
      end
    end
  end

  assign w_rowActive = (w_vcnt != 4'd0);

  // Column counter: loaded on the ball's left edge in an active row, counts
  // pixels down; cleared at each line start so a ball at the right edge
  // never spills onto the beginning of the next line.
  always_comb begin
    w_hcnt = 4'd0;
    if ((hpos == w_bh) && (w_bh != OFFSCR) && w_rowActive) begin
      w_hcnt = SZ;
    end else if (w_lineStart) begin
      w_hcnt = 4'd0;
    end else if (r_hcnt != 4'd0) begin
      w_hcnt = r_hcnt - 4'd1;
    end
  end

  assign w_inLine = ({1'b0, hpos} < H_END);
  assign w_pixel  = (w_hcnt != 4'd0) && w_rowActive && display_on && w_inLine;

  assign w_rowIdx  = SZ - w_vcnt;
  assign w_colIdx  = SZ - w_hcnt;
  assign w_edgeRow = (w_rowIdx == 4'd0) || (w_rowIdx == SZ_LAST);
  assign w_edgeCol = (w_colIdx == 4'd0) || (w_colIdx == SZ_LAST);

  // Side columns and interior overlap count as horizontal hits; top/bottom
  // rows count as vertical hits; a corner pixel is both.
  assign w_hitH = w_pixel && playfield_gfx && (w_edgeCol || !w_edgeRow);
  assign w_hitV = w_pixel && playfield_gfx && w_edgeRow;

  // Frame latch, counters, sticky hit flags and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bh        <= OFFSCR;
      r_bv        <= OFFSCR;
      r_vcnt      <= 4'd0;
      r_hcnt      <= 4'd0;
      r_stickyH   <= 1'b0;
      r_stickyV   <= 1'b0;
      r_ballGfx   <= 1'b0;
      r_hitHoriz  <= 1'b0;
      r_hitVert   <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      if (w_frameStart) begin
        r_bh <= ball_hpos;
        r_bv <= ball_vpos;
      end
      r_vcnt      <= w_vcnt;
      r_hcnt      <= w_hcnt;
      r_stickyH   <= (w_frameStart ? 1'b0 : r_stickyH) | w_hitH;
      r_stickyV   <= (w_frameStart ? 1'b0 : r_stickyV) | w_hitV;
      r_ballGfx   <= w_pixel;
      r_frameDone <= w_frameEnd;
      r_hitHoriz  <= w_frameEnd & r_stickyH;
      r_hitVert   <= w_frameEnd & r_stickyV;
    end
  end

  assign ball_gfx   = r_ballGfx;
  assign hit_horiz  = r_hitHoriz;
  assign hit_vert   = r_hitVert;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_ball_render.sv
// tb_ball_render: drives a compressed video beam (every line, but only a
// window of columns around the ball) and checks ball_render against a
// coordinate-range model plus per-frame hand-computed expectations.
module tb_ball_render;

  localparam int BS   = 4;
  localparam int HDSP = 256;
  localparam int VDSP = 240;
  localparam int VTOT = 242;

  logic       clk;
  logic       reset;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       display_on;
  logic [8:0] ball_hpos;
  logic [8:0] ball_vpos;
  logic       playfield_gfx;
  logic       ball_gfx;
  logic       hit_horiz;
  logic       hit_vert;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  // per-frame observations collected by the compare process
  int pixCount;
  int firstH;
  int firstV;
  int fdSeen;
  int fdH;
  int fdV;
  int gfxAfterReset;

  // model state
  int   mbh = 511;
  int   mbv = 511;
  bit   msh = 0;
  bit   msv = 0;
  bit   mValid = 0;
  logic [3:0] expOut;
  int   lastH;
  int   lastV;
  bit   lastRst;

  ball_render #(.BALL_SIZE(BS), .H_DISPLAY(HDSP), .V_DISPLAY(VDSP)) dut (
    .clk          (clk),
    .reset        (reset),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .ball_hpos    (ball_hpos),
    .ball_vpos    (ball_vpos),
    .playfield_gfx(playfield_gfx),
    .ball_gfx     (ball_gfx),
    .hit_horiz    (hit_horiz),
    .hit_vert     (hit_vert),
    .frame_done   (frame_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Model: the ball covers [bh, bh+BS) x [bv, bv+BS) in frame coordinates.
  task automatic modelStep();
    int h, v, col, row;
    bit inBall, edgeC, edgeR;
    h = int'(hpos);
    v = int'(vpos);
    lastH = h;
    lastV = v;
    lastRst = reset;
    if (reset) begin
      mbh = 511; mbv = 511; msh = 0; msv = 0;
      expOut = 4'b0000;
      mValid = 1;
    end else begin
      if (h == 0 && v == 0) begin
        mbh = int'(ball_hpos); mbv = int'(ball_vpos);
        msh = 0; msv = 0;
      end
      inBall = (mbh != 511) && (mbv != 511) &&
               (h >= mbh) && (h < mbh + BS) &&
               (v >= mbv) && (v < mbv + BS) && display_on;
      if (h == 0 && v == VDSP) expOut = {1'b0, 1'b1, msh, msv};
      else expOut = 4'b0000;
      expOut[3] = inBall;
      if (inBall && playfield_gfx) begin
        col = h - mbh;
        row = v - mbv;
        edgeC = (col == 0) || (col == BS - 1);
        edgeR = (row == 0) || (row == BS - 1);
        if (edgeR) msv = 1;
        if (edgeC || !edgeR) msh = 1;
      end
    end
  endtask

  // Compare process: model advances on the active edge, DUT checked on the
  // opposite edge.
  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      if (mValid) begin
        total++;
        if ({ball_gfx, frame_done, hit_horiz, hit_vert} !== expOut) begin
          bad++;
          $display("[TB] FAIL outputs beam=(%0d,%0d) actual=%b expected=%b",
                   lastH, lastV, {ball_gfx, frame_done, hit_horiz, hit_vert}, expOut);
        end
        if (ball_gfx === 1'b1) begin
          if (pixCount == 0) begin
            firstH = lastH;
            firstV = lastV;
          end
          pixCount++;
        end
        if (frame_done === 1'b1) begin
          fdSeen++;
          fdH = int'(hit_horiz);
          fdV = int'(hit_vert);
        end
        if (lastRst) gfxAfterReset = int'(ball_gfx);
      end
    end
  end

  function automatic logic pfPixel(input int mode, input int h, input int v);
    case (mode)
      1: return (h >= 20) && (v >= 11) && (v <= 12);
      2: return (v >= 13);
      3: return (h >= 101) && (h <= 102) && (v >= 13);
      4: return 1'b1;
      5: return (h == 0) && (v == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic applyStimulus(input int h, input int v, input int mode, input bit rst);
    hpos          = 9'(h);
    vpos          = 9'(v);
    display_on    = (h < HDSP) && (v < VDSP);
    playfield_gfx = pfPixel(mode, h, v);
    reset         = rst;
    @(posedge clk);
    #1;
  endtask

  // One frame: every line presents hpos 0 and then a contiguous column window.
  task automatic runFrame(input int hLo, input int hHi, input int mode,
                          input bit chgAtV5, input bit rstAtV11);
    pixCount = 0; firstH = -1; firstV = -1;
    fdSeen = 0; fdH = -1; fdV = -1; gfxAfterReset = -1;
    for (int v = 0; v < VTOT; v++) begin
      if (chgAtV5 && v == 5) ball_hpos = 9'd40;
      applyStimulus(0, v, mode, 1'b0);
      for (int h = hLo; h <= hHi; h++) begin
        if (h != 0) applyStimulus(h, v, mode, rstAtV11 && v == 11 && h == 19);
      end
    end
  endtask

  task automatic checkFrame(input string tag, input int pix, input int fh, input int fv,
                            input int hh, input int hv);
    checkOutput({tag, " pixels"}, pixCount, pix);
    checkOutput({tag, " first hpos"}, firstH, fh);
    checkOutput({tag, " first vpos"}, firstV, fv);
    checkOutput({tag, " frame_done count"}, fdSeen, 1);
    checkOutput({tag, " hit_horiz"}, fdH, hh);
    checkOutput({tag, " hit_vert"}, fdV, hv);
  endtask

  initial begin
    ball_hpos = 9'd18;
    ball_vpos = 9'd10;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1'b1);
    checkOutput("reset ball_gfx", int'(ball_gfx), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset hits", int'({hit_horiz, hit_vert}), 0);

    $display("[TB] draw");
    runFrame(10, 30, 0, 0, 0);
    checkFrame("draw", 16, 18, 10, 0, 0);

    $display("[TB] right wall");
    runFrame(10, 30, 1, 0, 0);
    checkFrame("wall", 16, 18, 10, 1, 0);

    $display("[TB] floor corner");
    ball_hpos = 9'd100;
    runFrame(95, 110, 2, 0, 0);
    checkFrame("floor", 16, 100, 10, 1, 1);

    $display("[TB] floor middle");
    runFrame(95, 110, 3, 0, 0);
    checkFrame("floormid", 16, 100, 10, 0, 1);

    $display("[TB] latch timing");
    ball_hpos = 9'd18;
    runFrame(10, 50, 0, 1, 0);
    checkFrame("latch cur", 16, 18, 10, 0, 0);
    runFrame(10, 50, 0, 0, 0);
    checkFrame("latch next", 16, 40, 10, 0, 0);

    $display("[TB] clipping");
    ball_hpos = 9'd254;
    ball_vpos = 9'd238;
    runFrame(248, 263, 0, 0, 0);
    checkFrame("clip", 4, 254, 238, 0, 0);

    $display("[TB] reset mid-frame");
    ball_hpos = 9'd18;
    ball_vpos = 9'd10;
    runFrame(10, 30, 4, 0, 1);
    checkFrame("midreset", 5, 18, 10, 0, 0);
    checkOutput("midreset gfx after reset", gfxAfterReset, 0);

    $display("[TB] origin ball");
    ball_hpos = 9'd0;
    ball_vpos = 9'd0;
    runFrame(1, 10, 5, 0, 0);
    checkFrame("origin", 16, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
